int_issue_queue: RTL and testbench

- Single-port out-of-order issue queue that sits directly downstream of dispatch.
- Accepts one renamed, ROB-tagged instruction per cycle and tracks readiness of its two physical sources via writeback wakeups.
- Each cycle it selects one ready entry and issues it to an integer execution pipe.
- Squashes entries younger than a redirect.

---
 rtl/int_isq_pkg.sv | 46 ++++
 rtl/int_issue_queue_if.sv | 60 ++++++
 rtl/int_isq_select.sv | 39 +++
 rtl/int_issue_queue.sv | 148 ++++++++++++++
 tb/tb_int_issue_queue.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_isq_pkg.sv
// int_isq_pkg: shared types and helpers for the integer issue queue.
// Holds the entry record, the ROB age compare (used by select and flush),
// and the free-slot / priority-encoder helpers (sized for up to SEL_MAX entries).
package int_isq_pkg;

  localparam int PREG_W      = 6;   // physical register tag width
  localparam int ROB_W       = 5;   // ROB index width (wrap flag carried separately)
  localparam int SEL_MAX     = 64;  // widest entry vector the helpers handle
  localparam int SEL_MAX_LOG = 6;

  // Per-entry control state; the wide payload lives in a side array because
  // its width is an instance parameter.
  typedef struct packed {
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic              src1_is_reg;
    logic              src2_is_reg;
    logic              src1_rdy;
    logic              src2_rdy;
    logic              rob_flag;
    logic [ROB_W-1:0]  rob_idx;
  } isq_entry_t;

  // True when (fa,ia) is strictly older than (fb,ib); the flag flips on ROB wrap.
  function automatic logic is_older(input logic fa, input logic [ROB_W-1:0] ia,
                                    input logic fb, input logic [ROB_W-1:0] ib);
    return ((fa == fb) && (ia < ib)) || ((fa != fb) && (ia > ib));
  endfunction

  // Isolate the lowest set bit.
  function automatic logic [SEL_MAX-1:0] pe_onehot(input logic [SEL_MAX-1:0] v);
    return v & (~v + SEL_MAX'(1));
  endfunction

  // Index of the lowest set bit (0 when none set; callers gate on "any").
  function automatic logic [SEL_MAX_LOG-1:0] lowest_set_idx(input logic [SEL_MAX-1:0] v);
    logic [SEL_MAX_LOG-1:0] idx;
    idx = '0;
    for (int i = SEL_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = SEL_MAX_LOG'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// int_issue_queue_if: dispatch, wakeup, flush and issue signals of the issue queue.
// master = dispatch/writeback/execute side, slave = the queue itself.
// Widths follow int_isq_pkg; DEPTH/PAYLOAD_W must match the queue instance.
interface int_issue_queue_if #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 128
);
  localparam int PW = int_isq_pkg::PREG_W;
  localparam int RW = int_isq_pkg::ROB_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 enq_valid;
  logic                 enq_ready;
  logic [PW-1:0]        enq_prs1;
  logic [PW-1:0]        enq_prs2;
  logic                 enq_src1_is_reg;
  logic                 enq_src2_is_reg;
  logic                 enq_src1_busy;
  logic                 enq_src2_busy;
  logic [PW-1:0]        enq_prd;
  logic                 enq_robidx_flag;
  logic [RW-1:0]        enq_robidx;
  logic [PAYLOAD_W-1:0] enq_payload;
  logic                 wb0_valid;
  logic                 wb1_valid;
  logic [PW-1:0]        wb0_prd;
  logic [PW-1:0]        wb1_prd;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [PW-1:0]        iss_prs1;
  logic [PW-1:0]        iss_prs2;
  logic [PW-1:0]        iss_prd;
  logic                 iss_src1_is_reg;
  logic                 iss_src2_is_reg;
  logic                 iss_robidx_flag;
  logic [RW-1:0]        iss_robidx;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic                 flush_valid;
  logic                 flush_robidx_flag;
  logic [RW-1:0]        flush_robidx;
  logic [CW-1:0]        count;

  modport master (
    output enq_valid, enq_prs1, enq_prs2, enq_src1_is_reg, enq_src2_is_reg,
           enq_src1_busy, enq_src2_busy, enq_prd, enq_robidx_flag, enq_robidx,
           enq_payload, wb0_valid, wb1_valid, wb0_prd, wb1_prd, iss_ready,
           flush_valid, flush_robidx_flag, flush_robidx,
    input  enq_ready, iss_valid, iss_prs1, iss_prs2, iss_prd, iss_src1_is_reg,
           iss_src2_is_reg, iss_robidx_flag, iss_robidx, iss_payload, count
  );

  modport slave (
    input  enq_valid, enq_prs1, enq_prs2, enq_src1_is_reg, enq_src2_is_reg,
           enq_src1_busy, enq_src2_busy, enq_prd, enq_robidx_flag, enq_robidx,
           enq_payload, wb0_valid, wb1_valid, wb0_prd, wb1_prd, iss_ready,
           flush_valid, flush_robidx_flag, flush_robidx,
    output enq_ready, iss_valid, iss_prs1, iss_prs2, iss_prd, iss_src1_is_reg,
           iss_src2_is_reg, iss_robidx_flag, iss_robidx, iss_payload, count
  );
endinterface

// File: rtl/int_isq_select.sv
// int_isq_select: picks one eligible entry and returns a one-hot grant.
// Purely combinational (0 cycles); no backpressure of its own.
// INT_ISQ_AGE_SELECT_EN: oldest by ROB age; otherwise lowest index wins.
module int_isq_select
  import int_isq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            i_elig,
  input  logic [DEPTH-1:0]            i_rob_flag,
  input  logic [DEPTH-1:0][ROB_W-1:0] i_rob_idx,
  output logic [DEPTH-1:0]            o_grant,
  output logic                        o_valid
);

  assign o_valid = |i_elig;

`ifdef INT_ISQ_AGE_SELECT_EN
  // Oldest eligible entry wins; equal ages fall back to lower index so the grant stays one-hot.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && i_elig[j]) begin
          if (is_older(i_rob_flag[j], i_rob_idx[j], i_rob_flag[i], i_rob_idx[i]) ||
              ((j < i) && (i_rob_flag[j] == i_rob_flag[i]) && (i_rob_idx[j] == i_rob_idx[i])))
            o_grant[i] = 1'b0;
        end
      end
    end
  end
`else
  logic w_unused_age;
  assign o_grant      = DEPTH'(pe_onehot(SEL_MAX'(i_elig)));
  assign w_unused_age = ^{i_rob_flag, i_rob_idx};
`endif

endmodule

// File: rtl/int_issue_queue.sv
// int_issue_queue: out-of-order integer issue queue with wakeup, select and ROB-age flush.
// Latency: enqueue-to-issue min 1 cycle (same-cycle wakeup bypass at enqueue).
// Backpressure: enq_ready from registered count (and not during flush); iss held while iss_ready low.
// Option macro INT_ISQ_AGE_SELECT_EN switches select from lowest-index to oldest-first.
module int_issue_queue
  import int_isq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  int_issue_queue_if.slave   io
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  isq_entry_t            r_ent   [DEPTH];
  logic [PAYLOAD_W-1:0]  r_pay   [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [CW-1:0]         r_count;

  isq_entry_t            w_ent_nxt [DEPTH];
  isq_entry_t            w_enq_ent;
  logic [DEPTH-1:0]      w_valid_nxt;
  logic [DEPTH-1:0]      w_elig;
  logic [DEPTH-1:0]      w_grant;
  logic                  w_any;
  logic [DEPTH-1:0]      w_rob_flag;
  logic [DEPTH-1:0][ROB_W-1:0] w_rob_idx;
  logic [IW-1:0]         w_free_idx;
  logic                  w_enq_fire;
  logic                  w_iss_fire;

  // Handshakes; an entry freed by issue only becomes reusable once count updates.
  assign io.enq_ready = ~reset & (r_count < CW'(DEPTH)) & ~io.flush_valid;
  assign w_enq_fire   = io.enq_valid & io.enq_ready;
  assign io.iss_valid = w_any & ~io.flush_valid;
  assign w_iss_fire   = io.iss_valid & io.iss_ready;
  assign io.count     = r_count;
  assign w_free_idx   = IW'(lowest_set_idx(SEL_MAX'(~r_valid)));

  // Eligibility vector and age fields for the selector.
  always_comb begin
    w_elig     = '0;
    w_rob_flag = '0;
    w_rob_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_elig[i]     = r_valid[i] & r_ent[i].src1_rdy & r_ent[i].src2_rdy;
      w_rob_flag[i] = r_ent[i].rob_flag;
      w_rob_idx[i]  = r_ent[i].rob_idx;
    end
  end

  int_isq_select #(.DEPTH(DEPTH)) u_select (
    .i_elig     (w_elig),
    .i_rob_flag (w_rob_flag),
    .i_rob_idx  (w_rob_idx),
    .o_grant    (w_grant),
    .o_valid    (w_any)
  );

  // Issue mux driven by the one-hot grant.
  always_comb begin
    io.iss_prs1        = '0;
    io.iss_prs2        = '0;
    io.iss_prd         = '0;
    io.iss_src1_is_reg = 1'b0;
    io.iss_src2_is_reg = 1'b0;
    io.iss_robidx_flag = 1'b0;
    io.iss_robidx      = '0;
    io.iss_payload     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        io.iss_prs1        = r_ent[i].prs1;
        io.iss_prs2        = r_ent[i].prs2;
        io.iss_prd         = r_ent[i].prd;
        io.iss_src1_is_reg = r_ent[i].src1_is_reg;
        io.iss_src2_is_reg = r_ent[i].src2_is_reg;
        io.iss_robidx_flag = r_ent[i].rob_flag;
        io.iss_robidx      = r_ent[i].rob_idx;
        io.iss_payload     = r_pay[i];
      end
    end
  end

  // Incoming entry, with readiness bypassed from this cycle's writebacks.
  always_comb begin
    w_enq_ent             = '0;
    w_enq_ent.prs1        = io.enq_prs1;
    w_enq_ent.prs2        = io.enq_prs2;
    w_enq_ent.prd         = io.enq_prd;
    w_enq_ent.src1_is_reg = io.enq_src1_is_reg;
    w_enq_ent.src2_is_reg = io.enq_src2_is_reg;
    w_enq_ent.rob_flag    = io.enq_robidx_flag;
    w_enq_ent.rob_idx     = io.enq_robidx;
    w_enq_ent.src1_rdy    = ~io.enq_src1_is_reg | ~io.enq_src1_busy |
                            (io.wb0_valid & (io.wb0_prd == io.enq_prs1)) |
                            (io.wb1_valid & (io.wb1_prd == io.enq_prs1));
    w_enq_ent.src2_rdy    = ~io.enq_src2_is_reg | ~io.enq_src2_busy |
                            (io.wb0_valid & (io.wb0_prd == io.enq_prs2)) |
                            (io.wb1_valid & (io.wb1_prd == io.enq_prs2));
  end

  // Next state: wakeup, flush of younger entries, issue dealloc, then enqueue.
  always_comb begin
    w_valid_nxt = r_valid;
    w_ent_nxt   = r_ent;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ent[i].src1_is_reg &&
          ((io.wb0_valid && (io.wb0_prd == r_ent[i].prs1)) ||
           (io.wb1_valid && (io.wb1_prd == r_ent[i].prs1))))
        w_ent_nxt[i].src1_rdy = 1'b1;
      if (r_ent[i].src2_is_reg &&
          ((io.wb0_valid && (io.wb0_prd == r_ent[i].prs2)) ||
           (io.wb1_valid && (io.wb1_prd == r_ent[i].prs2))))
        w_ent_nxt[i].src2_rdy = 1'b1;
      if (io.flush_valid &&
          is_older(io.flush_robidx_flag, io.flush_robidx, r_ent[i].rob_flag, r_ent[i].rob_idx))
        w_valid_nxt[i] = 1'b0;
    end
    if (w_iss_fire) w_valid_nxt = w_valid_nxt & ~w_grant;
    if (w_enq_fire) begin
      w_valid_nxt[w_free_idx] = 1'b1;
      w_ent_nxt[w_free_idx]   = w_enq_ent;
    end
  end

  // Control state registers; count tracks the population of the valid vector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= CW'($countones(w_valid_nxt));
      r_ent   <= w_ent_nxt;
    end
  end

  // Payload storage, written only on enqueue (no reset needed: guarded by valid).
  always_ff @(posedge clock) begin
    if (w_enq_fire) r_pay[w_free_idx] <= io.enq_payload;
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// tb_int_issue_queue: table-driven enqueue/wakeup vectors plus hand sequences
// for full queue, hold, flush, select order and mid-run reset; issued entries
// are checked against a scoreboard of expected issues.
`timescale 1ns/1ps
module tb_int_issue_queue;
  import int_isq_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = 128;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int_issue_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) ifc ();

  int_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clock (clock),
    .reset (reset),
    .io    (ifc)
  );

  typedef struct {
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic              r1;
    logic              r2;
    logic              flag;
    logic [ROB_W-1:0]  idx;
    logic [PW-1:0]     pay;
  } iss_exp_t;

  typedef struct {
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic              r1;
    logic              r2;
    logic              b1;
    logic              b2;
    logic              w0v;
    logic [PREG_W-1:0] w0p;
    logic              w1v;
    logic [PREG_W-1:0] w1p;
    logic              exp_rdy;
  } vec_t;

  iss_exp_t sb[$];
  iss_exp_t m_e;
  vec_t     vt[8];
  int       n_cmp = 0;
  int       n_bad = 0;
  logic     hold  = 1'b0;
  logic [PW-1:0] pay;
  logic [PW-1:0] fpay[8];
  logic [PW-1:0] bpay[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ifc.enq_valid = 1'b0; ifc.enq_prs1 = '0; ifc.enq_prs2 = '0;
    ifc.enq_src1_is_reg = 1'b0; ifc.enq_src2_is_reg = 1'b0;
    ifc.enq_src1_busy = 1'b0; ifc.enq_src2_busy = 1'b0; ifc.enq_prd = '0;
    ifc.enq_robidx_flag = 1'b0; ifc.enq_robidx = '0; ifc.enq_payload = '0;
    ifc.wb0_valid = 1'b0; ifc.wb0_prd = '0; ifc.wb1_valid = 1'b0; ifc.wb1_prd = '0;
    ifc.flush_valid = 1'b0; ifc.flush_robidx_flag = 1'b0; ifc.flush_robidx = '0;
    ifc.iss_ready = ~hold;
  endtask

  task automatic enq(input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                     input logic r1, input logic r2, input logic b1, input logic b2,
                     input logic [PREG_W-1:0] prd, input logic fl,
                     input logic [ROB_W-1:0] ix, input logic [PW-1:0] pl);
    ifc.enq_valid = 1'b1; ifc.enq_prs1 = p1; ifc.enq_prs2 = p2;
    ifc.enq_src1_is_reg = r1; ifc.enq_src2_is_reg = r2;
    ifc.enq_src1_busy = b1; ifc.enq_src2_busy = b2; ifc.enq_prd = prd;
    ifc.enq_robidx_flag = fl; ifc.enq_robidx = ix; ifc.enq_payload = pl;
  endtask

  task automatic push_exp(input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                          input logic r1, input logic r2, input logic [PREG_W-1:0] prd,
                          input logic fl, input logic [ROB_W-1:0] ix, input logic [PW-1:0] pl);
    iss_exp_t e;
    e.prs1 = p1; e.prs2 = p2; e.r1 = r1; e.r2 = r2; e.prd = prd;
    e.flag = fl; e.idx = ix; e.pay = pl;
    sb.push_back(e);
  endtask

  function automatic logic [PW-1:0] rnd_pay();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: every accepted issue must match the next expected record.
  always @(negedge clock) begin
    if (!reset && ifc.iss_valid && ifc.iss_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_issue: got prd=%0d rob=%0d:%0d, want no issue (t=%0t)",
                 ifc.iss_prd, ifc.iss_robidx_flag, ifc.iss_robidx, $time);
      end else begin
        m_e = sb.pop_front();
        if (ifc.iss_prd !== m_e.prd || ifc.iss_prs1 !== m_e.prs1 || ifc.iss_prs2 !== m_e.prs2 ||
            ifc.iss_src1_is_reg !== m_e.r1 || ifc.iss_src2_is_reg !== m_e.r2 ||
            ifc.iss_robidx_flag !== m_e.flag || ifc.iss_robidx !== m_e.idx ||
            ifc.iss_payload !== m_e.pay) begin
          n_bad++;
          $display("FAIL issue_fields: got prd=%0d prs=%0d/%0d rob=%0d:%0d pay=%0h want prd=%0d prs=%0d/%0d rob=%0d:%0d pay=%0h",
                   ifc.iss_prd, ifc.iss_prs1, ifc.iss_prs2, ifc.iss_robidx_flag, ifc.iss_robidx,
                   ifc.iss_payload, m_e.prd, m_e.prs1, m_e.prs2, m_e.flag, m_e.idx, m_e.pay);
        end
      end
    end
  end

  initial begin
    //        prs1   prs2   r1 r2 b1 b2 w0v w0p    w1v w1p    rdy
    vt[0] = '{6'd5,  6'd6,  1, 1, 1, 0, 1, 6'd5,  0, 6'd0,  1};
    vt[1] = '{6'd5,  6'd6,  1, 1, 1, 1, 1, 6'd5,  1, 6'd6,  1};
    vt[2] = '{6'd5,  6'd6,  1, 1, 1, 1, 1, 6'd5,  0, 6'd0,  0};
    vt[3] = '{6'd7,  6'd8,  0, 0, 1, 1, 0, 6'd0,  0, 6'd0,  1};
    vt[4] = '{6'd9,  6'd9,  1, 1, 0, 0, 0, 6'd0,  0, 6'd0,  1};
    vt[5] = '{6'd10, 6'd11, 1, 1, 0, 1, 0, 6'd0,  1, 6'd12, 0};
    vt[6] = '{6'd3,  6'd4,  1, 1, 1, 1, 1, 6'd4,  1, 6'd3,  1};
    vt[7] = '{6'd1,  6'd2,  1, 0, 1, 1, 0, 6'd0,  0, 6'd0,  0};

    // Reset state
    idle();
    @(negedge clock);
    chk("rst_count", 32'(ifc.count), 0);
    chk("rst_iss_valid", 32'(ifc.iss_valid), 0);
    chk("rst_enq_ready", 32'(ifc.enq_ready), 0);
    nxt();
    reset = 1'b0;
    @(negedge clock);
    chk("rel_enq_ready", 32'(ifc.enq_ready), 1);

    // Single-entry vectors: readiness at enqueue including same-cycle bypass
    for (int k = 0; k < 8; k++) begin
      nxt(); idle();
      pay = rnd_pay();
      enq(vt[k].prs1, vt[k].prs2, vt[k].r1, vt[k].r2, vt[k].b1, vt[k].b2,
          6'(40 + k), k[0], 5'(k), pay);
      ifc.wb0_valid = vt[k].w0v; ifc.wb0_prd = vt[k].w0p;
      ifc.wb1_valid = vt[k].w1v; ifc.wb1_prd = vt[k].w1p;
      if (vt[k].exp_rdy)
        push_exp(vt[k].prs1, vt[k].prs2, vt[k].r1, vt[k].r2, 6'(40 + k), k[0], 5'(k), pay);
      @(negedge clock);
      chk("vec_enq_ready", 32'(ifc.enq_ready), 1);
      nxt(); idle();
      @(negedge clock);
      chk("vec_iss_valid", 32'(ifc.iss_valid), 32'(vt[k].exp_rdy));
      chk("vec_count", 32'(ifc.count), 1);
      if (!vt[k].exp_rdy) begin
        nxt(); idle();
        ifc.wb0_valid = 1'b1; ifc.wb0_prd = vt[k].prs1;
        ifc.wb1_valid = 1'b1; ifc.wb1_prd = vt[k].prs2;
        push_exp(vt[k].prs1, vt[k].prs2, vt[k].r1, vt[k].r2, 6'(40 + k), k[0], 5'(k), pay);
        @(negedge clock);
        chk("vec_wake_cycle_iss", 32'(ifc.iss_valid), 0);
        nxt(); idle();
        @(negedge clock);
        chk("vec_woken_iss", 32'(ifc.iss_valid), 1);
      end
      nxt(); idle();
      @(negedge clock);
      chk("vec_drained", 32'(ifc.count), 0);
    end

    // Full queue: no enqueue while full, freed slot reusable one cycle after issue
    for (int i = 0; i < 8; i++) begin
      nxt(); idle();
      fpay[i] = rnd_pay();
      enq(6'(16 + i), 6'(32 + i), 1, 1, 1, 1, 6'(48 + i), 1'b0, 5'(i), fpay[i]);
    end
    nxt(); idle();
    @(negedge clock);
    chk("full_count", 32'(ifc.count), 8);
    chk("full_enq_ready", 32'(ifc.enq_ready), 0);
    chk("full_iss_valid", 32'(ifc.iss_valid), 0);
    nxt(); idle();
    ifc.wb0_valid = 1'b1; ifc.wb0_prd = 6'd19;
    ifc.wb1_valid = 1'b1; ifc.wb1_prd = 6'd35;
    push_exp(6'd19, 6'd35, 1, 1, 6'd51, 1'b0, 5'd3, fpay[3]);
    nxt(); idle();
    enq(6'd60, 6'd61, 1, 1, 1, 1, 6'd62, 1'b0, 5'd20, rnd_pay());
    @(negedge clock);
    chk("full_issue_cycle_iss", 32'(ifc.iss_valid), 1);
    chk("full_issue_cycle_enq_ready", 32'(ifc.enq_ready), 0);
    nxt(); idle();
    @(negedge clock);
    chk("after_issue_enq_ready", 32'(ifc.enq_ready), 1);
    chk("after_issue_count", 32'(ifc.count), 7);
    nxt(); idle();
    ifc.flush_valid = 1'b1; ifc.flush_robidx_flag = 1'b0; ifc.flush_robidx = 5'd0;
    @(negedge clock);
    chk("flush0_enq_ready", 32'(ifc.enq_ready), 0);
    nxt(); idle();
    ifc.wb0_valid = 1'b1; ifc.wb0_prd = 6'd16;
    ifc.wb1_valid = 1'b1; ifc.wb1_prd = 6'd32;
    push_exp(6'd16, 6'd32, 1, 1, 6'd48, 1'b0, 5'd0, fpay[0]);
    @(negedge clock);
    chk("flush0_survivors", 32'(ifc.count), 1);
    nxt(); idle();
    @(negedge clock);
    chk("flush0_survivor_iss", 32'(ifc.iss_valid), 1);
    nxt(); idle();
    @(negedge clock);
    chk("full_seq_drained", 32'(ifc.count), 0);

    // Hold with iss_ready low, then flush at f0:6 removes only f1:1
    hold = 1'b1;
    for (int i = 0; i < 3; i++) bpay[i] = rnd_pay();
    nxt(); idle(); enq(6'd1, 6'd2, 1, 1, 0, 0, 6'd10, 1'b0, 5'd2, bpay[0]);
    nxt(); idle(); enq(6'd3, 6'd4, 1, 1, 1, 1, 6'd11, 1'b0, 5'd6, bpay[1]);
    nxt(); idle(); enq(6'd5, 6'd6, 1, 1, 1, 1, 6'd12, 1'b1, 5'd1, bpay[2]);
    for (int c = 0; c < 4; c++) begin
      nxt(); idle();
      @(negedge clock);
      chk("hold_iss_valid", 32'(ifc.iss_valid), 1);
      chk("hold_count", 32'(ifc.count), 3);
    end
    hold = 1'b0;
    nxt(); idle();
    ifc.flush_valid = 1'b1; ifc.flush_robidx_flag = 1'b0; ifc.flush_robidx = 5'd6;
    ifc.wb0_valid = 1'b1; ifc.wb0_prd = 6'd3;
    ifc.wb1_valid = 1'b1; ifc.wb1_prd = 6'd4;
    enq(6'd7, 6'd8, 1, 1, 1, 1, 6'd13, 1'b0, 5'd9, rnd_pay());
    @(negedge clock);
    chk("flush_cycle_iss_valid", 32'(ifc.iss_valid), 0);
    chk("flush_cycle_enq_ready", 32'(ifc.enq_ready), 0);
    push_exp(6'd1, 6'd2, 1, 1, 6'd10, 1'b0, 5'd2, bpay[0]);
    push_exp(6'd3, 6'd4, 1, 1, 6'd11, 1'b0, 5'd6, bpay[1]);
    nxt(); idle();
    @(negedge clock);
    chk("flush_count", 32'(ifc.count), 2);
    chk("post_flush_iss", 32'(ifc.iss_valid), 1);
    nxt(); idle();
    @(negedge clock);
    chk("post_flush_count1", 32'(ifc.count), 1);
    chk("woken_in_flush_iss", 32'(ifc.iss_valid), 1);
    nxt(); idle();
    @(negedge clock);
    chk("flush_seq_drained", 32'(ifc.count), 0);

    // Select order across a ROB wrap: f1:0 at index0, f0:7 at index1
    hold = 1'b1;
    bpay[0] = rnd_pay(); bpay[1] = rnd_pay();
    nxt(); idle(); enq(6'd1, 6'd2, 1, 1, 0, 0, 6'd20, 1'b1, 5'd0, bpay[0]);
    nxt(); idle(); enq(6'd3, 6'd4, 1, 1, 0, 0, 6'd21, 1'b0, 5'd7, bpay[1]);
    hold = 1'b0;
    nxt(); idle();
`ifdef INT_ISQ_AGE_SELECT_EN
    push_exp(6'd3, 6'd4, 1, 1, 6'd21, 1'b0, 5'd7, bpay[1]);
    push_exp(6'd1, 6'd2, 1, 1, 6'd20, 1'b1, 5'd0, bpay[0]);
`else
    push_exp(6'd1, 6'd2, 1, 1, 6'd20, 1'b1, 5'd0, bpay[0]);
    push_exp(6'd3, 6'd4, 1, 1, 6'd21, 1'b0, 5'd7, bpay[1]);
`endif
    @(negedge clock);
    chk("sel_iss_valid", 32'(ifc.iss_valid), 1);
    chk("sel_count2", 32'(ifc.count), 2);
    nxt(); idle();
    @(negedge clock);
    chk("sel_count1", 32'(ifc.count), 1);
    nxt(); idle();
    @(negedge clock);
    chk("sel_drained", 32'(ifc.count), 0);

    // Mid-run reset with three waiting entries
    nxt(); idle(); enq(6'd30, 6'd31, 1, 1, 1, 1, 6'd40, 1'b0, 5'd1, rnd_pay());
    nxt(); idle(); enq(6'd30, 6'd31, 1, 1, 1, 1, 6'd41, 1'b0, 5'd2, rnd_pay());
    nxt(); idle(); enq(6'd30, 6'd31, 1, 1, 1, 1, 6'd42, 1'b0, 5'd3, rnd_pay());
    nxt(); idle();
    @(negedge clock);
    chk("pre_reset_count", 32'(ifc.count), 3);
    nxt();
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_count", 32'(ifc.count), 0);
    chk("midrst_iss_valid", 32'(ifc.iss_valid), 0);
    chk("midrst_enq_ready", 32'(ifc.enq_ready), 0);
    nxt();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_rel_enq_ready", 32'(ifc.enq_ready), 1);
    chk("midrst_rel_count", 32'(ifc.count), 0);
    nxt(); idle();
    @(negedge clock);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
